rr_queue_arbiter: RTL and testbench

//   Round-robin arbiter sharing one val/rdy queue write port between p_num_reqs
//   val/rdy requesters. Typical sink: w_* side of a bisynchronous normal queue.
//   A registered output stage gives 1-cycle latency and full throughput.

---
 rtl/rr_queue_arbiter_if.sv | 31 +++
 rtl/rr_queue_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_queue_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_queue_arbiter_if.sv
// Request/response bundle between p_num_reqs val/rdy requesters, the
// round-robin arbiter and the downstream queue write port.
//   in_val/in_msg : requester valids and packed messages (req i at [i*W +: W])
//   in_rdy        : per-requester ready, one-hot or zero
//   out_val/out_msg/out_src : registered output stream and its source index
//   out_rdy       : downstream ready
// slave  = arbiter side, master = environment (requesters + sink) side.
interface rr_queue_arbiter_if #(
  parameter int unsigned p_num_reqs   = 4,
  parameter int unsigned p_data_width = 32
);
  localparam int unsigned src_w = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

  logic [p_num_reqs-1:0]              in_val;
  logic [p_num_reqs-1:0]              in_rdy;
  logic [p_num_reqs*p_data_width-1:0] in_msg;
  logic                               out_val;
  logic                               out_rdy;
  logic [p_data_width-1:0]            out_msg;
  logic [src_w-1:0]                   out_src;

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_src
  );

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_src
  );
endinterface

// File: rtl/rr_queue_arbiter.sv
// Round-robin arbiter sharing one val/rdy write port between p_num_reqs
// requesters, with a registered output stage (1-cycle latency, full rate)
// and optional burst locking of up to p_max_burst consecutive grants.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : rr_queue_arbiter_if.slave (in_val/in_rdy/in_msg, out_*)
module rr_queue_arbiter #(
  parameter int unsigned p_num_reqs   = 4,
  parameter int unsigned p_data_width = 32,
  parameter int unsigned p_max_burst  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  rr_queue_arbiter_if.slave bus
);
  localparam int unsigned n_reqs = p_num_reqs;
  localparam int unsigned data_w = p_data_width;
  localparam int unsigned src_w  = (n_reqs > 1) ? $clog2(n_reqs) : 1;
  localparam int unsigned cnt_w  = $clog2(p_max_burst + 1);

  logic              out_val_q, out_val_d;
  logic [data_w-1:0] out_msg_q, out_msg_d;
  logic [src_w-1:0]  out_src_q, out_src_d;
  logic [src_w-1:0]  holder_q,  holder_d;
  logic [cnt_w-1:0]  cnt_q,     cnt_d;

  logic              accept_c;
  logic              lock_c;
  logic              grant_vld_c;
  logic [src_w-1:0]  grant_idx_c;
  logic [n_reqs-1:0] in_rdy_c;
  logic              xfer_c;
  logic [data_w-1:0] msg_sel_c;

  // Output stage can load whenever it is empty or draining this cycle.
  assign accept_c = ~out_val_q | bus.out_rdy;

  // Grant selection. A zero count means no burst is in progress (only seen
  // after reset), so the holder is not locked and the search starts at
  // holder+1, which makes the first post-reset grant the lowest valid index.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    lock_c      = bus.in_val[holder_q] && (cnt_q != '0) &&
                  (cnt_q < cnt_w'(p_max_burst));
    if (lock_c) begin
      grant_vld_c = 1'b1;
      grant_idx_c = holder_q;
    end else begin
      for (int unsigned k = 1; k <= n_reqs; k++) begin
        if (!grant_vld_c &&
            bus.in_val[src_w'((32'(holder_q) + k) % n_reqs)]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = src_w'((32'(holder_q) + k) % n_reqs);
        end
      end
    end
  end

  // Ready to the granted requester only; nothing while in reset.
  always_comb begin
    in_rdy_c = '0;
    if (grant_vld_c && accept_c && reset_n) begin
      in_rdy_c = n_reqs'(1) << grant_idx_c;
    end
  end

  assign bus.in_rdy = in_rdy_c;
  assign xfer_c     = |(bus.in_val & in_rdy_c);

  // Message mux for the granted requester.
  always_comb begin
    msg_sel_c = '0;
    for (int unsigned i = 0; i < n_reqs; i++) begin
      if (src_w'(i) == grant_idx_c) begin
        msg_sel_c = bus.in_msg[i*data_w +: data_w];
      end
    end
  end

  // Next state: holder/count/priority move only on a transfer.
  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    holder_d  = holder_q;
    cnt_d     = cnt_q;
    if (xfer_c) begin
      out_val_d = 1'b1;
      out_msg_d = msg_sel_c;
      out_src_d = grant_idx_c;
      if (grant_idx_c == holder_q) begin
        if (cnt_q < cnt_w'(p_max_burst)) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end else begin
        holder_d = grant_idx_c;
        cnt_d    = cnt_w'(1);
      end
    end else if (out_val_q && bus.out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
      holder_q  <= src_w'(n_reqs - 1);
      cnt_q     <= '0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
      holder_q  <= holder_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_val = out_val_q;
  assign bus.out_msg = out_msg_q;
  assign bus.out_src = out_src_q;
endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Self-checking bench for rr_queue_arbiter: two instances (burst 1 and
// burst 4) share stimulus; checks target the selected instance against a
// transaction-level model of the arbitration rules.
module tb_rr_queue_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int PD = 256;

  logic clk;
  logic reset_n;
  logic [NR-1:0]    drv_val;
  logic [NR*DW-1:0] drv_msg;
  logic             drv_out_rdy;
  logic             cfg_b1;

  logic [NR-1:0] obs_rdy;
  logic          obs_val;
  logic [DW-1:0] obs_msg;
  logic [1:0]    obs_src;

  int n_chk, n_fail;

  rr_queue_arbiter_if #(.p_num_reqs(NR), .p_data_width(DW)) if_a ();
  rr_queue_arbiter_if #(.p_num_reqs(NR), .p_data_width(DW)) if_b ();

  rr_queue_arbiter #(.p_num_reqs(NR), .p_data_width(DW), .p_max_burst(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  rr_queue_arbiter #(.p_num_reqs(NR), .p_data_width(DW), .p_max_burst(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));

  assign if_a.in_val  = drv_val;
  assign if_a.in_msg  = drv_msg;
  assign if_a.out_rdy = drv_out_rdy;
  assign if_b.in_val  = drv_val;
  assign if_b.in_msg  = drv_msg;
  assign if_b.out_rdy = drv_out_rdy;

  always_comb begin
    if (cfg_b1) begin
      obs_rdy = if_a.in_rdy; obs_val = if_a.out_val;
      obs_msg = if_a.out_msg; obs_src = if_a.out_src;
    end else begin
      obs_rdy = if_b.in_rdy; obs_val = if_b.out_val;
      obs_msg = if_b.out_msg; obs_src = if_b.out_src;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester message FIFOs: head is presented, popped on transfer.
  logic [DW-1:0] pmem [NR][PD];
  int ph [NR];
  int pt [NR];
  int seq_push [NR];

  // Reference model state.
  logic          m_val;
  logic [DW-1:0] m_msg;
  int            m_src, m_holder, m_cnt;

  // Observed output beats.
  int            beat_src[$];
  logic [DW-1:0] beat_msg[$];

  function automatic int pcount(int i);
    return pt[i] - ph[i];
  endfunction

  task automatic push(int i, logic [DW-1:0] m);
    if (pt[i] < PD) begin
      pmem[i][pt[i]] = m;
      pt[i]++;
    end
  endtask

  // Tagged message: requester index in upper half, per-requester sequence below.
  task automatic push_seq(int i);
    push(i, (DW'(i) << 16) | DW'(seq_push[i]));
    seq_push[i]++;
  endtask

  task automatic refill_all();
    for (int i = 0; i < NR; i++) if (pcount(i) < 2) push_seq(i);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      drv_val[i] = (pcount(i) > 0);
      drv_msg[i*DW +: DW] = (pcount(i) > 0) ? pmem[i][ph[i]] : '0;
    end
  endtask

  task automatic model_reset();
    m_val = 1'b0; m_msg = '0; m_src = 0; m_holder = NR - 1; m_cnt = 0;
  endtask

  // Arbitration rule: stay with a holder that is mid-burst and still
  // requesting, otherwise the next requester after the holder in ring order.
  function automatic int exp_grant(int mb);
    if (m_cnt > 0 && m_cnt < mb && pcount(m_holder) > 0) return m_holder;
    for (int k = 1; k <= NR; k++)
      if (pcount((m_holder + k) % NR) > 0) return (m_holder + k) % NR;
    return -1;
  endfunction

  // One clock: drive, check at negedge, advance the model, cross posedge.
  task automatic step();
    int g, mb;
    logic acc;
    logic [NR-1:0] exp_rdy;
    apply_inputs();
    @(negedge clk);
    mb  = cfg_b1 ? 1 : 4;
    g   = exp_grant(mb);
    acc = !m_val || drv_out_rdy;
    exp_rdy = '0;
    if (g >= 0 && acc) exp_rdy = NR'(1) << g;
    n_chk++;
    if (obs_rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_rdy t=%0t got %b expected %b", $time, obs_rdy, exp_rdy);
    end
    n_chk++;
    if (obs_val !== m_val) begin
      n_fail++;
      $display("FAIL out_val t=%0t got %b expected %b", $time, obs_val, m_val);
    end
    if (m_val) begin
      n_chk++;
      if (obs_msg !== m_msg) begin
        n_fail++;
        $display("FAIL out_msg t=%0t got %h expected %h", $time, obs_msg, m_msg);
      end
      n_chk++;
      if (obs_src !== 2'(m_src)) begin
        n_fail++;
        $display("FAIL out_src t=%0t got %0d expected %0d", $time, obs_src, m_src);
      end
    end
    if (obs_val && drv_out_rdy) begin
      beat_src.push_back(int'(obs_src));
      beat_msg.push_back(obs_msg);
    end
    if (g >= 0 && acc) begin
      m_val = 1'b1;
      m_msg = pmem[g][ph[g]];
      m_src = g;
      ph[g]++;
      if (g == m_holder) begin
        if (m_cnt < mb) m_cnt++;
      end else begin
        m_holder = g;
        m_cnt    = 1;
      end
    end else if (m_val && drv_out_rdy) begin
      m_val = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin ph[i] = 0; pt[i] = 0; seq_push[i] = 0; end
    apply_inputs();
    model_reset();
    beat_src.delete();
    beat_msg.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Every beat must carry the next sequence number of its source.
  task automatic check_beat_order(string tag);
    int nxt [NR];
    for (int i = 0; i < NR; i++) nxt[i] = 0;
    foreach (beat_src[k]) begin
      n_chk++;
      if (beat_msg[k] !== ((DW'(beat_src[k]) << 16) | DW'(nxt[beat_src[k]]))) begin
        n_fail++;
        $display("FAIL %s beat %0d msg got %h src %0d seq expected %0d",
                 tag, k, beat_msg[k], beat_src[k], nxt[beat_src[k]]);
      end
      nxt[beat_src[k]]++;
    end
  endtask

  task automatic test_reset();
    cfg_b1 = 1'b0;
    do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin push_seq(i); push_seq(i); end
    apply_inputs();
    @(negedge clk);
    n_chk++;
    if (obs_rdy !== 4'b0000 || if_a.in_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_in_rdy got %b/%b expected 0000", obs_rdy, if_a.in_rdy);
    end
    n_chk++;
    if (obs_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_val got %b expected 0", obs_val);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drv_out_rdy = 1'b1;
    repeat (3) begin refill_all(); step(); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs_val !== 1'b0 || obs_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset got out_val=%b in_rdy=%b expected 0/0000", obs_val, obs_rdy);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_inputs();
    #1;
    n_chk++;
    if (obs_rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant_after_reset got %b expected 0001", obs_rdy);
    end
    @(posedge clk);
    #1;
    model_reset();
    do_reset();
  endtask

  task automatic test_single_req2();
    cfg_b1 = 1'b0;
    do_reset();
    drv_out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) push(2, 32'hA0 + DW'(k));
    repeat (11) step();
    n_chk++;
    if (beat_src.size() != 8) begin
      n_fail++;
      $display("FAIL req2_beats got %0d expected 8", beat_src.size());
    end
    foreach (beat_src[k]) begin
      n_chk++;
      if (beat_msg[k] !== 32'hA0 + DW'(k) || beat_src[k] != 2) begin
        n_fail++;
        $display("FAIL req2_beat%0d got msg %h src %0d expected %h src 2",
                 k, beat_msg[k], beat_src[k], 32'hA0 + DW'(k));
      end
    end
  endtask

  task automatic test_stream(logic b1, int beats, string tag);
    int burst;
    cfg_b1 = b1;
    burst  = b1 ? 1 : 4;
    do_reset();
    drv_out_rdy = 1'b1;
    repeat (beats + 1) begin refill_all(); step(); end
    n_chk++;
    if (beat_src.size() != beats) begin
      n_fail++;
      $display("FAIL %s_beats got %0d expected %0d", tag, beat_src.size(), beats);
    end
    foreach (beat_src[k]) begin
      n_chk++;
      if (beat_src[k] != (k / burst) % NR) begin
        n_fail++;
        $display("FAIL %s_src%0d got %0d expected %0d", tag, k, beat_src[k], (k / burst) % NR);
      end
    end
    check_beat_order(tag);
  endtask

  task automatic test_stall();
    cfg_b1 = 1'b0;
    do_reset();
    drv_out_rdy = 1'b1;
    repeat (4) begin refill_all(); step(); end
    drv_out_rdy = 1'b0;
    repeat (3) begin refill_all(); step(); end
    drv_out_rdy = 1'b1;
    repeat (6) begin refill_all(); step(); end
    n_chk++;
    if (beat_src.size() != 9) begin
      n_fail++;
      $display("FAIL stall_beats got %0d expected 9", beat_src.size());
    end
    check_beat_order("stall");
  endtask

  task automatic test_drop();
    int exp_src [6] = '{1, 1, 3, 3, 3, 3};
    cfg_b1 = 1'b0;
    do_reset();
    drv_out_rdy = 1'b1;
    push_seq(1); push_seq(1);
    repeat (4) push_seq(3);
    repeat (8) step();
    n_chk++;
    if (beat_src.size() != 6) begin
      n_fail++;
      $display("FAIL drop_beats got %0d expected 6", beat_src.size());
    end
    for (int k = 0; k < 6 && k < beat_src.size(); k++) begin
      n_chk++;
      if (beat_src[k] != exp_src[k]) begin
        n_fail++;
        $display("FAIL drop_src%0d got %0d expected %0d", k, beat_src[k], exp_src[k]);
      end
    end
  endtask

  task automatic test_random(logic b1);
    cfg_b1 = b1;
    do_reset();
    repeat (200) begin
      for (int i = 0; i < NR; i++)
        if (pcount(i) < 2 && $urandom_range(0, 2) == 0) push_seq(i);
      drv_out_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    check_beat_order(b1 ? "rand_b1" : "rand_b4");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    cfg_b1 = 1'b0;
    drv_val = '0;
    drv_msg = '0;
    drv_out_rdy = 1'b1;
    model_reset();
    test_reset();
    test_single_req2();
    test_stream(1'b1, 12, "rr_b1");
    test_stream(1'b0, 16, "burst4");
    test_stall();
    test_drop();
    test_random(1'b1);
    test_random(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
